rr_pkt_mux_arb: RTL and testbench

//  Two-source packet arbiter and output register that sits directly upstream of the 2:1 select mux and drives its select.

---
 rtl/mux_pkg.sv | 14 +
 rtl/pipe_reg.sv | 50 +++++
 rtl/rr_pkt_mux_arb.sv | 127 ++++++++++++
 tb/tb_rr_pkt_mux_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types for the two-source round-robin packet arbiter.
// Holds the arbiter FSM state type and the source id encoding.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/pipe_reg.sv
// Single-entry valid/ready output register.
// Ports: in_valid/in_data/in_ready load side,
// out_valid/out_data/out_ready drain side.
// in_ready is the load enable: empty or draining.
module pipe_reg #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Data keeps its last value when nothing
  // loads, so sel stays steady for the mux.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/rr_pkt_mux_arb.sv
// Two-source per-packet round-robin arbiter with
// registered output beat and source select (sel).
// Ports: a_*/b_* source valid/data/last/ready,
// y_* registered beat, sel = source of y (0=A, 1=B).
module rr_pkt_mux_arb
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  output logic              y_last,
  input  logic              y_ready,
  output logic              sel
);

  localparam int W = DATA_W + 2;

  arb_state_t state_q;
  arb_state_t state_d;
  logic       prio_q;
  logic       prio_d;

  logic              load_en;
  logic              gnt_vld;
  logic              gnt_src;
  logic              acc;
  logic              acc_last;
  logic [DATA_W-1:0] acc_data;
  logic [W-1:0]      out_bus;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = SRC_A;
    unique case (state_q)
      LOCK_A: begin
        gnt_vld = 1'b1;
        gnt_src = SRC_A;
      end
      LOCK_B: begin
        gnt_vld = 1'b1;
        gnt_src = SRC_B;
      end
      default: begin
        if (a_valid && b_valid) begin
          gnt_vld = 1'b1;
          gnt_src = prio_q;
        end else if (a_valid) begin
          gnt_vld = 1'b1;
          gnt_src = SRC_A;
        end else if (b_valid) begin
          gnt_vld = 1'b1;
          gnt_src = SRC_B;
        end
      end
    endcase
  end

  assign a_ready = rst_n && load_en && gnt_vld
                   && (gnt_src == SRC_A);
  assign b_ready = rst_n && load_en && gnt_vld
                   && (gnt_src == SRC_B);

  always_comb begin
    acc      = a_valid && a_ready;
    acc_last = a_last;
    acc_data = a_data;
    if (gnt_src == SRC_B) begin
      acc      = b_valid && b_ready;
      acc_last = b_last;
      acc_data = b_data;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (acc) begin
      if (acc_last) begin
        state_d = IDLE;
        prio_d  = ~gnt_src;
      end else if (gnt_src == SRC_B) begin
        state_d = LOCK_B;
      end else begin
        state_d = LOCK_A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= SRC_A;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  pipe_reg #(
    .W(W)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (acc),
    .in_data  ({gnt_src, acc_last, acc_data}),
    .in_ready (load_en),
    .out_valid(y_valid),
    .out_data (out_bus),
    .out_ready(y_ready)
  );

  assign sel    = out_bus[W-1];
  assign y_last = out_bus[W-2];
  assign y_data = out_bus[DATA_W-1:0];

endmodule

// File: tb/tb_rr_pkt_mux_arb.sv
// Directed bench for rr_pkt_mux_arb with a
// packet-level reference model checked every cycle.
module tb_rr_pkt_mux_arb;

  logic       clk;
  logic       rst_n;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_last;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_last;
  logic       b_ready;
  logic       y_valid;
  logic [7:0] y_data;
  logic       y_last;
  logic       y_ready;
  logic       sel;

  int n_chk;
  int n_fail;

  // reference model: owner of current packet
  // (-1 none), next preferred source, output reg
  int       m_lock;
  int       m_prio;
  bit       m_v;
  bit [7:0] m_d;
  bit       m_l;
  bit       m_s;

  // beats leaving the output: {sel, data}
  logic [8:0] outq[$];

  rr_pkt_mux_arb #(.DATA_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_valid(a_valid),
    .a_data (a_data),
    .a_last (a_last),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_data (b_data),
    .b_last (b_last),
    .b_ready(b_ready),
    .y_valid(y_valid),
    .y_data (y_data),
    .y_last (y_last),
    .y_ready(y_ready),
    .sel    (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int m_grant();
    if (m_lock >= 0) return m_lock;
    if (a_valid && b_valid) return m_prio;
    if (a_valid) return 0;
    if (b_valid) return 1;
    return -1;
  endfunction

  // model step at the edge, compare mid-cycle
  initial begin
    int  g;
    bit  ld;
    bit  ea;
    bit  eb;
    m_lock = -1;
    m_prio = 0;
    m_v = 0;
    m_d = 0;
    m_l = 0;
    m_s = 0;
    forever begin
      @(posedge clk);
      g  = m_grant();
      ld = !m_v || y_ready;
      if (!rst_n) begin
        m_lock = -1;
        m_prio = 0;
        m_v = 0;
        m_d = 0;
        m_l = 0;
        m_s = 0;
      end else if (ld && g == 0 && a_valid) begin
        m_v = 1; m_d = a_data; m_l = a_last; m_s = 0;
        m_lock = a_last ? -1 : 0;
        if (a_last) m_prio = 1;
      end else if (ld && g == 1 && b_valid) begin
        m_v = 1; m_d = b_data; m_l = b_last; m_s = 1;
        m_lock = b_last ? -1 : 1;
        if (b_last) m_prio = 0;
      end else if (ld) begin
        m_v = 0;
      end
      #6;
      g  = m_grant();
      ld = !m_v || y_ready;
      ea = rst_n && ld && g == 0;
      eb = rst_n && ld && g == 1;
      chk("m_a_ready", 32'(a_ready), 32'(ea));
      chk("m_b_ready", 32'(b_ready), 32'(eb));
      chk("m_y_valid", 32'(y_valid), 32'(m_v));
      chk("m_y_data", 32'(y_data), 32'(m_d));
      chk("m_y_last", 32'(y_last), 32'(m_l));
      chk("m_sel", 32'(sel), 32'(m_s));
      if (y_valid && y_ready)
        outq.push_back({sel, y_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    a_valid = 0; a_data = 0; a_last = 0;
    b_valid = 0; b_data = 0; b_last = 0;
  endtask

  task automatic chk_q(input string nm,
                       input int idx,
                       input logic [8:0] exp);
    if (idx < outq.size())
      chk(nm, 32'(outq[idx]), 32'(exp));
    else
      chk({nm, "_missing"}, 32'(outq.size()),
          32'(idx + 1));
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    idle_in();
    y_ready = 1;
    rst_n = 0;

    // 1: reset with both sources requesting
    a_valid = 1; a_data = 8'hA5; a_last = 1;
    b_valid = 1; b_data = 8'h5A; b_last = 1;
    step();
    step();
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_b_ready", 32'(b_ready), 0);
    chk("rst_y_valid", 32'(y_valid), 0);
    chk("rst_sel", 32'(sel), 0);

    // 2: single beat from A
    rst_n = 1;
    idle_in();
    a_valid = 1; a_data = 8'h3C; a_last = 1;
    step();
    idle_in();
    chk("single_y_valid", 32'(y_valid), 1);
    chk("single_y_data", 32'(y_data), 32'h3C);
    chk("single_sel", 32'(sel), 0);
    chk("single_y_last", 32'(y_last), 1);
    a_valid = 1; a_last = 1;
    b_valid = 1; b_last = 1;
    #1;
    chk("prio_b_ready", 32'(b_ready), 1);
    chk("prio_a_ready", 32'(a_ready), 0);
    idle_in();
    step();
    rst_n = 0;
    step();
    rst_n = 1;

    // 3: contention, one-beat packets
    outq.delete();
    a_valid = 1; a_data = 8'h11; a_last = 1;
    b_valid = 1; b_data = 8'h22; b_last = 1;
    repeat (4) step();
    idle_in();
    #5;
    chk_q("rr_0", 0, 9'h011);
    chk_q("rr_1", 1, 9'h122);
    chk_q("rr_2", 2, 9'h011);
    chk_q("rr_3", 3, 9'h122);
    step();

    // 4: A locks for a 3-beat packet
    outq.delete();
    b_valid = 1; b_data = 8'h99; b_last = 1;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1;
      a_data = 8'h41 + 8'(i);
      a_last = (i == 2);
      #1;
      chk("lock_b_wait", 32'(b_ready), 0);
      chk("lock_a_go", 32'(a_ready), 1);
      step();
    end
    a_valid = 0; a_last = 0;
    #1;
    chk("lock_b_free", 32'(b_ready), 1);
    step();
    b_valid = 0;
    #5;
    chk_q("lock_0", 0, 9'h041);
    chk_q("lock_1", 1, 9'h042);
    chk_q("lock_2", 2, 9'h043);
    chk_q("lock_3", 3, 9'h199);
    step();

    // 5: backpressure
    a_valid = 1; a_data = 8'h55; a_last = 1;
    step();
    y_ready = 0;
    a_data = 8'h66;
    b_valid = 1; b_data = 8'h77; b_last = 1;
    repeat (3) begin
      step();
      chk("bp_y_data", 32'(y_data), 32'h55);
      chk("bp_sel", 32'(sel), 0);
      chk("bp_a_ready", 32'(a_ready), 0);
      chk("bp_b_ready", 32'(b_ready), 0);
    end
    y_ready = 1;
    #1;
    chk("bp_rel_b_ready", 32'(b_ready), 1);
    step();
    b_valid = 0;
    chk("bp_next_data", 32'(y_data), 32'h77);
    chk("bp_next_sel", 32'(sel), 1);
    step();
    idle_in();
    chk("bp_then_a", 32'(y_data), 32'h66);
    step();

    // 6: reset during a B packet
    b_valid = 1; b_data = 8'h81; b_last = 0;
    step();
    b_data = 8'h82;
    rst_n = 0;
    step();
    rst_n = 1;
    a_valid = 1; a_data = 8'hC1; a_last = 1;
    b_data = 8'h83;
    #1;
    chk("mrst_y_valid", 32'(y_valid), 0);
    chk("mrst_a_ready", 32'(a_ready), 1);
    chk("mrst_b_ready", 32'(b_ready), 0);
    step();
    idle_in();
    chk("mrst_y_data", 32'(y_data), 32'hC1);
    chk("mrst_sel", 32'(sel), 0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
